kbd_port: RTL and testbench
===========================

KBD_PORT -- requirements
Module: kbd_port

Interface
REQ-001 SHALL provide parameter DEPTH, default 8, meaning FIFO entries (power of two, 2..64).
REQ-002 SHALL provide clk25  input  1  25 MHz master clock; all state on rising edge.
REQ-003 SHALL provide rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide enable  input  1  CPU clock-enable strobe; qualifies all bus accesses.
REQ-005 SHALL provide cs  input  1  chip select for the 0xD010-0xD011 window.
REQ-006 SHALL provide address  input  1  0 = KBD data, 1 = KBDCR status/control.
REQ-007 SHALL provide w_en  input  1  bus write strobe.
REQ-008 SHALL provide din  input  8  CPU write data.
REQ-009 SHALL provide dout  output  8  CPU read data.
REQ-010 SHALL provide in_data  input  8  ASCII byte from keyboard or UART source.
REQ-011 SHALL provide in_valid  input  1  source byte valid.
REQ-012 SHALL provide in_ready  output  1  port can accept a byte.

Function
REQ-013 SHALL assert in_ready combinationally when count < DEPTH; a push SHALL occur only when in_valid & in_ready.
REQ-014 SHALL map in_data 0x61-0x7A to 0x41-0x5A and leave all other codes unchanged.
REQ-015 SHALL accept and silently discard 0x0A (LF) and 0x00, with no FIFO change.
REQ-016 SHALL store each kept byte as {1'b1, mapped[6:0]}, with bit7 forced high (Apple-1 convention).
REQ-017 SHALL make a pushed byte visible on dout and on KBDCR bit7 on the clock after the push.
REQ-018 SHALL drive dout combinationally: for address 0, the head entry, or 0x00 when empty; for address 1, {~empty, ovf, 6'b0}.
REQ-019 SHALL pop the head on a cycle with cs & enable & ~w_en & address==0 & ~empty; reads while empty SHALL have no effect.
REQ-020 SHALL pop at most once per enable strobe, regardless of how long cs is held.
REQ-021 SHALL perform both operations on a simultaneous push and pop, leaving count unchanged and preserving order.
REQ-022 SHALL NOT push when full, even if a pop occurs in the same cycle; in_ready reflects the pre-pop count.
REQ-023 SHALL set sticky ovf when in_valid is high while full for DEPTH consecutive clocks; ovf SHALL clear on any KBDCR read.
REQ-024 SHALL, on a write with cs & enable & w_en & address==1 & din[0]==1, flush the FIFO (count=0, pointers=0) and clear ovf; a push in the same cycle SHALL be dropped.
REQ-025 SHALL ignore writes to address 0.
REQ-026 SHALL wrap read and write pointers modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.

Reset
REQ-027 SHALL, on rst, asynchronously set count=0, pointers=0, ovf=0 and the stall counter=0, giving in_ready=1 and dout=0x00 on both addresses.
REQ-028 SHALL discard FIFO contents on rst asserted mid-operation; storage RAM need not be reset.

Structure
REQ-029 SHALL take KBD_ADDR, KBDCR_ADDR, ASCII_LF and ASCII_NUL from the shared apple1 package.
REQ-030 SHALL instantiate one sub-module, kbd_fifo: a synchronous FIFO (DEPTH, 8-bit data, push/pop/flush, full/empty/count).
REQ-031 SHALL keep case mapping, LF filtering, bus decode and ovf tracking in kbd_port.

Verification
REQ-032 SHALL cover: push 0x61 -> next clock KBDCR=0x80, KBD=0xC1; KBD read with enable -> KBDCR=0x00.
REQ-033 SHALL cover: push 0x0A then 0x0D -> only 0x8D is queued; count=1.
REQ-034 SHALL cover: push 8 bytes 0x41..0x48 -> in_ready=0; hold in_valid 8 clocks -> KBDCR=0xC0; 8 reads return 0xC1..0xC8 in order; KBDCR then 0x00.
REQ-035 SHALL cover: with 3 entries, push 0x42 on the same cycle as a pop -> count stays 3 and the order is preserved.
REQ-036 SHALL cover: write 0x01 to KBDCR with 5 entries queued -> KBDCR=0x00, KBD=0x00, in_ready=1.
REQ-037 SHALL cover: assert rst with 4 entries queued -> immediately in_ready=1 and KBDCR=0x00, with no pops after release.

Source files
------------

// File: rtl/apple1_pkg.sv
// Shared Apple-1 constants: PIA register map and the ASCII codes the
// keyboard path treats specially.
package apple1_pkg;

  // Register select within the 0xD010-0xD011 keyboard window.
  localparam logic KBD_ADDR   = 1'b0;
  localparam logic KBDCR_ADDR = 1'b1;

  // Codes the keyboard port swallows instead of queueing.
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_NUL = 8'h00;

  // Lower-case range folded onto upper case (the Apple-1 has no lower case).
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
  localparam logic [6:0] ASCII_CASE_OFFSET = 7'h20;

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous byte FIFO with push/pop/flush. Head entry is presented
// combinationally on dout; pushes when full and pops when empty are ignored.
module kbd_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk25,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [7:0]                 din,
  output logic [7:0]                 dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem[rd_ptr];

  // Storage write port.
  // NOTE: the RAM has no reset on purpose; count/pointers define what is valid,
  // and leaving it out of reset lets it map onto plain block/distributed RAM.
  always_ff @(posedge clk25) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; flush beats any push/pop that cycle.
  // NOTE: non-blocking assignments here so every register samples pre-edge
  // values, independent of statement order.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kbd_port.sv
// Apple-1 keyboard PIA port: folds incoming ASCII to upper case, drops LF/NUL,
// queues bytes with the strobe bit set, and exposes KBD / KBDCR to the CPU.
module kbd_port
  import apple1_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       enable,
  input  logic       cs,
  input  logic       address,
  input  logic       w_en,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] STALL_LAST = AW'(DEPTH - 1);

  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic          rd_strobe;
  logic          wr_strobe;
  logic          pop_req;
  logic          kbdcr_read;
  logic          flush;
  logic          accept;
  logic          discard;
  logic          is_lower;
  logic [6:0]    upper7;
  logic          fifo_push;

  logic [AW-1:0] stall;
  logic          ovf;
  logic          ovf_set;
  logic          unused_din;

  // Bus decode. enable is a one-clock CPU strobe, so a read pops at most once
  // per access however long cs stays asserted.
  assign rd_strobe  = cs & enable & ~w_en;
  assign wr_strobe  = cs & enable & w_en;
  assign pop_req    = rd_strobe & (address == KBD_ADDR) & ~fifo_empty;
  assign kbdcr_read = rd_strobe & (address == KBDCR_ADDR);
  assign flush      = wr_strobe & (address == KBDCR_ADDR) & din[0];
  assign unused_din = ^din[7:1];

  // Source handshake. in_ready comes from the pre-pop count, so a full queue
  // refuses a byte even when the CPU drains one in the same cycle.
  assign in_ready = (fifo_count < CW'(DEPTH));
  assign accept   = in_valid & in_ready;
  assign discard  = (in_data == ASCII_LF) | (in_data == ASCII_NUL);

  // Case folding and strobe bit; codes outside a-z pass through.
  assign is_lower  = (in_data >= ASCII_LOWER_A) & (in_data <= ASCII_LOWER_Z);
  assign upper7    = is_lower ? (in_data[6:0] - ASCII_CASE_OFFSET) : in_data[6:0];
  assign fifo_push = accept & ~discard & ~flush;

  kbd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk25 (clk25),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (pop_req),
    .flush (flush),
    .din   ({1'b1, upper7}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Overflow fires once the source has been held off for DEPTH straight clocks.
  assign ovf_set = in_valid & fifo_full & (stall == STALL_LAST);

  // Stall run-length counter and sticky overflow flag. A fresh overflow wins
  // over a same-cycle KBDCR read: the CPU saw the old flag, not the new event.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      stall <= '0;
      ovf   <= 1'b0;
    end else if (flush) begin
      stall <= '0;
      ovf   <= 1'b0;
    end else begin
      if (in_valid & fifo_full) begin
        if (stall != STALL_LAST) stall <= stall + 1'b1;
      end else begin
        stall <= '0;
      end
      if (ovf_set)         ovf <= 1'b1;
      else if (kbdcr_read) ovf <= 1'b0;
    end
  end

  // CPU read mux; an empty queue reads as 0x00 so stale RAM never leaks out.
  // NOTE: dout gets a default first so no path through the block infers a latch.
  always_comb begin
    dout = 8'h00;
    if (address == KBD_ADDR) begin
      if (!fifo_empty) dout = fifo_dout;
    end else begin
      dout = {~fifo_empty, ovf, 6'b0};
    end
  end

endmodule

// File: tb/tb_kbd_port.sv
// Self-checking bench for kbd_port: mapping table, directed corner cases and
// a randomized run against a queue-based reference model.
module tb_kbd_port;

  localparam int DEPTH = 8;

  logic       clk25 = 1'b0;
  logic       rst;
  logic       enable;
  logic       cs;
  logic       address;
  logic       w_en;
  logic [7:0] din;
  logic [7:0] dout;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  always #20 clk25 = ~clk25;

  kbd_port #(.DEPTH(DEPTH)) dut (
    .clk25    (clk25),
    .rst      (rst),
    .enable   (enable),
    .cs       (cs),
    .address  (address),
    .w_en     (w_en),
    .din      (din),
    .dout     (dout),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the queue holds stored bytes, run counts consecutive
  // clocks with in_valid high against a full queue.
  logic [7:0] model_q[$];
  logic       model_ovf;
  int         model_run;

  typedef struct {
    logic [7:0] in_byte;
    logic [7:0] exp_kbd;
    logic [7:0] exp_kbdcr;
  } map_vec_t;

  map_vec_t vecs[12];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_store(input logic [7:0] b);
    logic [7:0] m;
    m = b;
    if (b >= 8'h61 && b <= 8'h7A) m = b - 8'h20;
    return 8'h80 | (m & 8'h7F);
  endfunction

  function automatic logic [7:0] model_dout(input logic a);
    if (a == 1'b0) return (model_q.size() != 0) ? model_q[0] : 8'h00;
    return {(model_q.size() != 0), model_ovf, 6'b0};
  endfunction

  function automatic void model_reset();
    model_q.delete();
    model_ovf = 1'b0;
    model_run = 0;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  function automatic void model_update();
    bit ready, rd, pop, flush, crread, full;
    ready  = model_q.size() < DEPTH;
    full   = model_q.size() == DEPTH;
    rd     = cs && enable && !w_en;
    pop    = rd && !address && model_q.size() != 0;
    crread = rd && address;
    flush  = cs && enable && w_en && address && din[0];
    model_run = (in_valid && full) ? model_run + 1 : 0;
    if (flush) begin
      model_reset();
    end else begin
      if (pop) void'(model_q.pop_front());
      if (in_valid && ready && in_data != 8'h0A && in_data != 8'h00)
        model_q.push_back(model_store(in_data));
      if (model_run >= DEPTH) model_ovf = 1'b1;
      else if (crread)        model_ovf = 1'b0;
    end
  endfunction

  // One clock: compare combinational outputs with the model, then clock both.
  task automatic step(input string tag);
    #1;
    check({tag, ".ready"}, {7'b0, in_ready}, {7'b0, model_q.size() < DEPTH});
    check({tag, ".dout"}, dout, model_dout(address));
    model_update();
    @(posedge clk25);
    #1;
  endtask

  task automatic idle_bus();
    cs = 1'b0; enable = 1'b0; w_en = 1'b0; din = 8'h00;
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1; in_data = b;
    step("push");
    in_valid = 1'b0;
  endtask

  task automatic bus_read(input logic a, output logic [7:0] data);
    cs = 1'b1; enable = 1'b1; w_en = 1'b0; address = a;
    #1;
    data = dout;
    step("read");
    idle_bus();
  endtask

  task automatic bus_write(input logic a, input logic [7:0] d);
    cs = 1'b1; enable = 1'b1; w_en = 1'b1; address = a; din = d;
    step("write");
    idle_bus();
  endtask

  task automatic expect_reg(input string name, input logic a, input logic [7:0] exp);
    address = a;
    #1;
    check(name, dout, exp);
  endtask

  task automatic expect_ready(input string name, input logic exp);
    #1;
    check(name, {7'b0, in_ready}, {7'b0, exp});
  endtask

  task automatic do_reset();
    idle_bus(); in_valid = 1'b0; in_data = 8'h00; address = 1'b0;
    rst = 1'b1;
    model_reset();
    @(posedge clk25);
    @(posedge clk25);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] d;

    vecs[0]  = '{8'h61, 8'hC1, 8'h80};
    vecs[1]  = '{8'h7A, 8'hDA, 8'h80};
    vecs[2]  = '{8'h60, 8'hE0, 8'h80};
    vecs[3]  = '{8'h7B, 8'hFB, 8'h80};
    vecs[4]  = '{8'h41, 8'hC1, 8'h80};
    vecs[5]  = '{8'h0D, 8'h8D, 8'h80};
    vecs[6]  = '{8'h0A, 8'h00, 8'h00};
    vecs[7]  = '{8'h00, 8'h00, 8'h00};
    vecs[8]  = '{8'h8A, 8'h8A, 8'h80};
    vecs[9]  = '{8'hE1, 8'hE1, 8'h80};
    vecs[10] = '{8'hFF, 8'hFF, 8'h80};
    vecs[11] = '{8'h20, 8'hA0, 8'h80};

    do_reset();
    expect_ready("reset.ready", 1'b1);
    expect_reg("reset.kbd", 1'b0, 8'h00);
    expect_reg("reset.kbdcr", 1'b1, 8'h00);

    // Mapping table: push one byte, inspect both registers, flush.
    for (int i = 0; i < 12; i++) begin
      push_byte(vecs[i].in_byte);
      expect_reg($sformatf("map[%0d].kbd", i), 1'b0, vecs[i].exp_kbd);
      expect_reg($sformatf("map[%0d].kbdcr", i), 1'b1, vecs[i].exp_kbdcr);
      bus_write(1'b1, 8'h01);
    end

    // Lower-case push, visible next clock, KBD read clears the strobe.
    push_byte(8'h61);
    expect_reg("a.kbdcr", 1'b1, 8'h80);
    expect_reg("a.kbd", 1'b0, 8'hC1);
    bus_read(1'b0, d);
    check("a.read", d, 8'hC1);
    expect_reg("a.kbdcr_after", 1'b1, 8'h00);

    // LF is swallowed, CR queued; a single read empties the queue.
    push_byte(8'h0A);
    expect_reg("lf.kbdcr", 1'b1, 8'h00);
    push_byte(8'h0D);
    expect_reg("cr.kbd", 1'b0, 8'h8D);
    bus_read(1'b0, d);
    expect_reg("cr.count1", 1'b1, 8'h00);

    // Fill, stall into overflow, drain in order.
    for (int i = 0; i < 8; i++) push_byte(8'h41 + 8'(i));
    expect_ready("full.ready", 1'b0);
    in_valid = 1'b1; in_data = 8'h49;
    for (int i = 0; i < 7; i++) step("stall");
    expect_reg("stall7.kbdcr", 1'b1, 8'h80);
    step("stall");
    expect_reg("stall8.kbdcr", 1'b1, 8'hC0);
    in_valid = 1'b0;
    bus_read(1'b1, d);
    check("ovf.read", d, 8'hC0);
    expect_reg("ovf.cleared", 1'b1, 8'h80);
    for (int i = 0; i < 8; i++) begin
      bus_read(1'b0, d);
      check($sformatf("drain[%0d]", i), d, 8'hC1 + 8'(i));
    end
    expect_reg("drain.kbdcr", 1'b1, 8'h00);
    expect_ready("drain.ready", 1'b1);

    // Simultaneous push and pop with three entries queued.
    push_byte(8'h41); push_byte(8'h43); push_byte(8'h44);
    in_valid = 1'b1; in_data = 8'h42;
    cs = 1'b1; enable = 1'b1; w_en = 1'b0; address = 1'b0;
    #1;
    check("pp.head", dout, 8'hC1);
    step("pushpop");
    idle_bus(); in_valid = 1'b0;
    bus_read(1'b0, d); check("pp[0]", d, 8'hC3);
    bus_read(1'b0, d); check("pp[1]", d, 8'hC4);
    bus_read(1'b0, d); check("pp[2]", d, 8'hC2);
    expect_reg("pp.empty", 1'b1, 8'h00);

    // Full queue with a pop: the push is refused, one slot frees up.
    for (int i = 0; i < 8; i++) push_byte(8'h61 + 8'(i));
    in_valid = 1'b1; in_data = 8'h5A;
    cs = 1'b1; enable = 1'b1; w_en = 1'b0; address = 1'b0;
    step("fullpop");
    idle_bus(); in_valid = 1'b0;
    expect_ready("fullpop.ready", 1'b1);
    expect_reg("fullpop.head", 1'b0, 8'hC2);
    bus_write(1'b1, 8'h01);

    // Ignored writes, non-flushing KBDCR write, cs without enable.
    push_byte(8'h31); push_byte(8'h32);
    bus_write(1'b0, 8'h55);
    expect_reg("wr0.kbd", 1'b0, 8'hB1);
    bus_write(1'b1, 8'hFE);
    expect_reg("wr1.kbdcr", 1'b1, 8'h80);
    cs = 1'b1; enable = 1'b0; w_en = 1'b0; address = 1'b0;
    step("noen");
    expect_reg("noen.kbd", 1'b0, 8'hB1);
    cs = 1'b1; enable = 1'b1;
    step("hold");
    enable = 1'b0;
    step("hold");
    step("hold");
    idle_bus();
    expect_reg("hold.kbd", 1'b0, 8'hB2);
    bus_write(1'b1, 8'h01);

    // Flush with five entries and a competing push.
    for (int i = 0; i < 5; i++) push_byte(8'h70 + 8'(i));
    in_valid = 1'b1; in_data = 8'h41;
    cs = 1'b1; enable = 1'b1; w_en = 1'b1; address = 1'b1; din = 8'h01;
    step("flush");
    idle_bus(); in_valid = 1'b0;
    expect_reg("flush.kbdcr", 1'b1, 8'h00);
    expect_reg("flush.kbd", 1'b0, 8'h00);
    expect_ready("flush.ready", 1'b1);

    // Asynchronous reset mid-cycle with four entries queued.
    for (int i = 0; i < 4; i++) push_byte(8'h51 + 8'(i));
    #10;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst.ready", {7'b0, in_ready}, 8'h01);
    address = 1'b1; #1; check("arst.kbdcr", dout, 8'h00);
    address = 1'b0; #1; check("arst.kbd", dout, 8'h00);
    @(posedge clk25);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step("post_rst");
    expect_reg("post_rst.kbd", 1'b0, 8'h00);

    // Randomized traffic against the model, cycling through fill/mixed/drain.
    for (int i = 0; i < 1500; i++) begin
      int phase, pv, pr, rr, r;
      phase = (i / 100) % 3;
      pv = (phase == 0) ? 90 : (phase == 1) ? 60 : 30;
      pr = (phase == 0) ? 5 : (phase == 1) ? 30 : 60;
      in_valid = ($urandom_range(0, 99) < pv);
      r = $urandom_range(0, 9);
      if (r == 0)      in_data = 8'h0A;
      else if (r == 1) in_data = 8'h00;
      else if (r < 5)  in_data = 8'($urandom_range(8'h61, 8'h7A));
      else             in_data = 8'($urandom);
      rr = $urandom_range(0, 99);
      address = 1'($urandom_range(0, 1));
      din = 8'($urandom);
      if (rr < pr) begin
        cs = 1'b1; enable = ($urandom_range(0, 3) != 0); w_en = 1'b0;
      end else if (rr < pr + 2) begin
        cs = 1'b1; enable = 1'b1; w_en = 1'b1;
      end else begin
        cs = 1'($urandom_range(0, 1)); enable = 1'b0; w_en = 1'($urandom_range(0, 1));
      end
      step("rnd");
    end
    idle_bus(); in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
